wb_write_arb: RTL

- Owns the single register-file write port and arbitrates it between two writers.
- Writer 1 is the in-order MEM/WB pipeline result, which cannot be held.
- Writer 2 is long-latency unit (divider, multi-cycle multiply) results, delivered over a valid/ready handshake and buffered in a small FIFO.
- Keeps a per-register busy scoreboard for long ops, so decode can stall on RAW and WAW hazards. Raises a stall request when the buffer needs pipeline bubbles to drain.

---
 rtl/wb_write_arb_pkg.sv | 11 +
 rtl/lop_fifo.sv | 54 +++++
 rtl/wb_write_arb.sv | 131 +++++++++++++
 3 files changed

// File: rtl/wb_write_arb_pkg.sv
// Shared defaults for the register-file write-port arbiter and its long-op buffer.
package wb_write_arb_pkg;

    localparam int   ADDR_W_DEF     = 5;
    localparam int   DATA_W_DEF     = 32;
    localparam int   FIFO_DEPTH_DEF = 4;
    localparam int   STARVE_MAX_DEF = 8;
    localparam int   ZERO_REG       = 0;
    localparam logic WE_ON          = 1'b1;

endpackage

// File: rtl/lop_fifo.sv
// Long-op result buffer: circular storage with a separate occupancy count.
module lop_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 37
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // a push into a full buffer is only legal when the head leaves the same cycle
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_write_arb.sv
// Register-file write-port arbiter: pipeline writes win, buffered long-op results
// drain in the gaps; tracks outstanding long-op destinations and requests bubbles.
module wb_write_arb
    import wb_write_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pipe_we,
    input  logic [ADDR_W-1:0]    pipe_waddr,
    input  logic [DATA_W-1:0]    pipe_wdata,
    input  logic                 iss_valid,
    input  logic [ADDR_W-1:0]    iss_waddr,
    input  logic                 lop_valid,
    input  logic [ADDR_W-1:0]    lop_waddr,
    input  logic [DATA_W-1:0]    lop_wdata,
    output logic                 lop_ready,
    output logic                 we,
    output logic [ADDR_W-1:0]    waddr,
    output logic [DATA_W-1:0]    wdata,
    output logic [2**ADDR_W-1:0] busy,
    output logic                 stall_req,
    output logic                 waw_err
);

    localparam int NREG = 2**ADDR_W;
    localparam int EW   = ADDR_W + DATA_W;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int SW   = $clog2(STARVE_MAX + 1);

    logic [EW-1:0]     head;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [CW-1:0]     fifo_count, count_nxt;
    logic              fifo_full, fifo_empty;
    logic              pipe_win, push, pop, iss_set;
    logic [NREG-1:0]   busy_q, busy_nxt;
    logic [SW-1:0]     starve_q, starve_nxt;
    logic              stall_q, stall_nxt;
    logic              waw_q;

    assign pipe_win  = pipe_we && (pipe_waddr != ADDR_W'(ZERO_REG));
    assign iss_set   = iss_valid && (iss_waddr != ADDR_W'(ZERO_REG));
    assign lop_ready = rst && !fifo_full;
    // r0 results are acknowledged but never reach the register file
    assign push      = lop_valid && lop_ready && (lop_waddr != ADDR_W'(ZERO_REG));
    assign pop       = rst && !fifo_empty && !pipe_win;
    assign head_addr = head[EW-1:DATA_W];
    assign head_data = head[DATA_W-1:0];

    lop_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EW)
    ) u_lop_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({lop_waddr, lop_wdata}),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // write-port select
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (rst) begin
            if (pipe_win) begin
                we    = WE_ON;
                waddr = pipe_waddr;
                wdata = pipe_wdata;
            end else if (!fifo_empty) begin
                we    = WE_ON;
                waddr = head_addr;
                wdata = head_data;
            end
        end
    end

    // per-register scoreboard; a fresh issue outranks a retiring result
    for (genvar r = 0; r < NREG; r++) begin : g_busy
        if (r == ZERO_REG) begin : g_zero
            assign busy_nxt[r] = 1'b0;
        end else begin : g_reg
            assign busy_nxt[r] = (iss_set && (iss_waddr == ADDR_W'(r))) ||
                                 (busy_q[r] && !(pop && (head_addr == ADDR_W'(r))));
        end
    end

    always_comb begin
        starve_nxt = starve_q;
        if (pop || fifo_empty)
            starve_nxt = '0;
        else if (pipe_win && (starve_q != SW'(STARVE_MAX)))
            starve_nxt = starve_q + 1'b1;
    end

    always_comb begin
        count_nxt = fifo_count + CW'(push) - CW'(pop);
        stall_nxt = !pop && (stall_q ||
                             (starve_nxt == SW'(STARVE_MAX)) ||
                             (count_nxt == CW'(FIFO_DEPTH)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q   <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            waw_q    <= 1'b0;
        end else begin
            busy_q   <= busy_nxt;
            starve_q <= starve_nxt;
            stall_q  <= stall_nxt;
            waw_q    <= waw_q || (pipe_win && busy_q[pipe_waddr]);
        end
    end

    assign busy      = busy_q;
    assign stall_req = stall_q;
    assign waw_err   = waw_q;

endmodule
